// File: rtl/branch_history_tracker_if.sv
// Fetch-side predictor <-> branch history tracker bundle.
// master = fetch/resolve side, slave = tracker.
interface branch_history_tracker_if #(
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [HIST_W-1:0] his_index;
  logic              pred_valid;
  logic              pred_taken;
  logic              pred_ready;
  logic              res_valid;
  logic              res_taken;
  logic              upd_en;
  logic [HIST_W-1:0] upd_index;
  logic              upd_taken;
  logic              mispredict;
  logic [CW-1:0]     inflight;
  logic [15:0]       stat_resolved;
  logic [15:0]       stat_mispred;

  modport master (
    output pred_valid, pred_taken,
    output res_valid, res_taken,
    input  his_index, pred_ready,
    input  upd_en, upd_index, upd_taken,
    input  mispredict, inflight,
    input  stat_resolved, stat_mispred
  );

  modport slave (
    input  pred_valid, pred_taken,
    input  res_valid, res_taken,
    output his_index, pred_ready,
    output upd_en, upd_index, upd_taken,
    output mispredict, inflight,
    output stat_resolved, stat_mispred
  );
endinterface

// File: rtl/branch_history_tracker.sv
// Speculative global history + in-flight branch queue with mispredict repair.
// Optional counters built only when BHT_STATS_EN is defined.
module branch_history_tracker #(
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  branch_history_tracker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic              pred;
  } ent_t;

  ent_t              q [DEPTH];
  logic [HIST_W-1:0] spec_hist;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              upd_en;
  logic [HIST_W-1:0] upd_index;
  logic              upd_taken;
  logic              mispredict;

  logic ready;
  logic pop;
  logic miss;
  logic push;
  ent_t e;

  always_comb begin
    ready = count < CW'(DEPTH);
    e     = q[head];
    pop   = bus.res_valid && (count != '0);
    miss  = pop && (bus.res_taken != e.pred);
    // wrong-path push in a repair cycle is dropped
    push  = bus.pred_valid && ready && !miss;
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{hist: spec_hist, pred: bus.pred_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_hist  <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      upd_en     <= 1'b0;
      upd_index  <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_en     <= pop;
      mispredict <= miss;
      if (pop) begin
        upd_index <= e.hist;
        upd_taken <= bus.res_taken;
        head      <= head + PW'(1);
      end
      if (miss) begin
        count     <= '0;
        tail      <= head + PW'(1);
        spec_hist <= {e.hist[HIST_W-2:0], bus.res_taken};
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) begin
          tail      <= tail + PW'(1);
          spec_hist <= {spec_hist[HIST_W-2:0], bus.pred_taken};
        end
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [15:0] n_res;
  logic [15:0] n_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_res <= '0;
      n_mis <= '0;
    end else begin
      if (pop && n_res != 16'hFFFF) n_res <= n_res + 16'd1;
      if (miss && n_mis != 16'hFFFF) n_mis <= n_mis + 16'd1;
    end
  end

  assign bus.stat_resolved = n_res;
  assign bus.stat_mispred  = n_mis;
`else
  assign bus.stat_resolved = '0;
  assign bus.stat_mispred  = '0;
`endif

  assign bus.his_index  = spec_hist;
  assign bus.pred_ready = ready;
  assign bus.inflight   = count;
  assign bus.upd_en     = upd_en;
  assign bus.upd_index  = upd_index;
  assign bus.upd_taken  = upd_taken;
  assign bus.mispredict = mispredict;
endmodule

// File: tb/tb_branch_history_tracker.sv
// Bench for branch_history_tracker: directed scenarios + random traffic
// against a queue-based reference model.
module tb_branch_history_tracker;
  localparam int HIST_W = 4;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << HIST_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_history_tracker_if #(.HIST_W(HIST_W), .DEPTH(DEPTH)) bus ();

  branch_history_tracker #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int hist;
    bit pred;
  } ent_t;

  ent_t q [$];
  int   m_hist;
  bit   m_upd_en;
  int   m_idx;
  bit   m_ut;
  bit   m_mis;
  int   m_res;
  int   m_mp;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hist   = 0;
    m_upd_en = 0;
    m_idx    = 0;
    m_ut     = 0;
    m_mis    = 0;
    m_res    = 0;
    m_mp     = 0;
  endtask

  task automatic model_step(input bit r, input bit pv, input bit pt,
                            input bit rv, input bit rt);
    bit   can_push;
    ent_t e;
    if (r) begin
      model_reset();
      return;
    end
    can_push = q.size() < DEPTH;
    m_upd_en = 0;
    m_mis    = 0;
    if (rv && q.size() > 0) begin
      e        = q.pop_front();
      m_upd_en = 1;
      m_idx    = e.hist;
      m_ut     = rt;
      if (m_res < 65535) m_res++;
      if (rt != e.pred) begin
        m_mis  = 1;
        q.delete();
        m_hist = ((e.hist << 1) | int'(rt)) & MASK;
        if (m_mp < 65535) m_mp++;
      end
    end
    if (!m_mis && pv && can_push) begin
      q.push_back('{hist: m_hist, pred: pt});
      m_hist = ((m_hist << 1) | int'(pt)) & MASK;
    end
  endtask

  task automatic compare_all();
    chk("his_index", int'(bus.his_index), m_hist);
    chk("inflight", int'(bus.inflight), q.size());
    chk("pred_ready", int'(bus.pred_ready), int'(q.size() < DEPTH));
    chk("upd_en", int'(bus.upd_en), int'(m_upd_en));
    chk("upd_index", int'(bus.upd_index), m_idx);
    chk("upd_taken", int'(bus.upd_taken), int'(m_ut));
    chk("mispredict", int'(bus.mispredict), int'(m_mis));
`ifdef BHT_STATS_EN
    chk("stat_resolved", int'(bus.stat_resolved), m_res);
    chk("stat_mispred", int'(bus.stat_mispred), m_mp);
`else
    chk("stat_resolved", int'(bus.stat_resolved), 0);
    chk("stat_mispred", int'(bus.stat_mispred), 0);
`endif
  endtask

  task automatic cyc(input bit r, input bit pv, input bit pt,
                     input bit rv, input bit rt);
    rst            = r;
    bus.pred_valid = pv;
    bus.pred_taken = pt;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    #1;
    if (!r) chk("pre_ready", int'(bus.pred_ready), int'(q.size() < DEPTH));
    model_step(r, pv, pt, rv, rt);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    bus.pred_valid = 1'b0;
    bus.pred_taken = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_taken  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // reset dominates active inputs
    cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 1, 1, 1);
    chk("rst_his", int'(bus.his_index), 0);
    chk("rst_ready", int'(bus.pred_ready), 1);

    // fill
    cyc(0, 1, 1, 0, 0);
    chk("fill1", int'(bus.his_index), 4'b0001);
    cyc(0, 1, 1, 0, 0);
    chk("fill2", int'(bus.his_index), 4'b0011);
    cyc(0, 1, 0, 0, 0);
    chk("fill3", int'(bus.his_index), 4'b0110);
    cyc(0, 1, 1, 0, 0);
    chk("fill4", int'(bus.his_index), 4'b1101);
    chk("full_ready", int'(bus.pred_ready), 0);
    cyc(0, 1, 0, 0, 0);
    chk("full_hold", int'(bus.his_index), 4'b1101);

    // correct resolves
    cyc(0, 0, 0, 1, 1);
    chk("res1_idx", int'(bus.upd_index), 4'b0000);
    chk("res1_inf", int'(bus.inflight), 3);
    cyc(0, 0, 0, 1, 1);
    chk("res2_idx", int'(bus.upd_index), 4'b0001);

    // third entry predicted not-taken, actual taken
    cyc(0, 0, 0, 1, 1);
    chk("mis_a", int'(bus.mispredict), 1);
    chk("rep_a", int'(bus.his_index), 4'b0111);
`ifdef BHT_STATS_EN
    chk("stats_res", int'(bus.stat_resolved), 3);
    chk("stats_mp", int'(bus.stat_mispred), 1);
`endif

    // mispredict from reset
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("s4_his", int'(bus.his_index), 4'b0011);
    cyc(0, 0, 0, 1, 0);
    chk("s4_mis", int'(bus.mispredict), 1);
    chk("s4_idx", int'(bus.upd_index), 0);
    chk("s4_his2", int'(bus.his_index), 0);
    chk("s4_inf", int'(bus.inflight), 0);

    // mispredict colliding with a push
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("col_inf", int'(bus.inflight), 0);
    chk("col_his", int'(bus.his_index), 4'b0000);
    cyc(0, 0, 0, 1, 1);
    chk("empty_upd", int'(bus.upd_en), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 2) != 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
